// File: rtl/axi_ic_pkg.sv
// Shared interconnect types: B-channel response codes and the master index type.
package axi_ic_pkg;

  typedef logic [1:0] bresp_t;
  typedef logic       master_idx_t;

  localparam bresp_t BRESP_OKAY   = 2'b00;
  localparam bresp_t BRESP_EXOKAY = 2'b01;
  localparam bresp_t BRESP_SLVERR = 2'b10;
  localparam bresp_t BRESP_DECERR = 2'b11;

  // Contents of the registered B output stage.
  typedef struct packed {
    logic        valid;
    master_idx_t sel;
    bresp_t      resp;
  } out_stage_t;

endpackage

// File: rtl/write_resp_router_if.sv
// One AXI4 write-response (B) channel. The master modport is the view of
// whoever consumes responses, the slave modport the view of whoever returns them.
interface write_resp_router_if;
  import axi_ic_pkg::*;

  logic   bvalid;
  bresp_t bresp;
  logic   bready;

  modport master (input bvalid, input bresp, output bready);
  modport slave  (output bvalid, output bresp, input bready);
endinterface

// File: rtl/wr_owner_fifo.sv
// In-order FIFO of 1-bit owner indices, one entry per outstanding write.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module wr_owner_fifo
  import axi_ic_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           push,
  input  master_idx_t                    push_data,
  input  logic                           pop,
  output master_idx_t                    head,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  master_idx_t        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: the array has no reset; an entry is only read after it has been written.
  always_ff @(posedge ACLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/write_resp_router.sv
// Routes B responses from the single downstream slave back to the upstream
// master that issued each write, using an in-order FIFO of owner indices and
// a one-entry registered output stage.
// Optional feature: define B_ERR_CHECK_EN to accept and flag stray responses
// and push-while-full violations on the sticky unexp_err output.
module write_resp_router
  import axi_ic_pkg::*;
#(
  parameter int unsigned OT_DEPTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              aw_push,
  input  master_idx_t                       aw_owner,
  output logic                              ot_full,
  output logic [$clog2(OT_DEPTH+1)-1:0]     ot_count,
  write_resp_router_if.master               S_AXI,
  write_resp_router_if.slave                M00_AXI,
  write_resp_router_if.slave                M01_AXI,
  output logic                              unexp_err
);

  out_stage_t  out_q, out_d;
  master_idx_t fifo_head;
  logic        fifo_empty, fifo_full;
  logic        sel_bready, out_free, b_hs, fifo_pop;

  wr_owner_fifo #(.DEPTH(OT_DEPTH)) u_owner_fifo (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .push      (aw_push),
    .push_data (aw_owner),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (ot_count)
  );

  assign ot_full = fifo_full;

  // Only the selected master's ready can drain the stage; the other is ignored.
  assign sel_bready = (out_q.sel == 1'b1) ? M01_AXI.bready : M00_AXI.bready;
  assign out_free   = !out_q.valid || sel_bready;

`ifdef B_ERR_CHECK_EN
  // With nothing outstanding, swallow any response so a stray one cannot stall the slave.
  assign S_AXI.bready = fifo_empty || out_free;
`else
  assign S_AXI.bready = !fifo_empty && out_free;
`endif

  assign b_hs     = S_AXI.bvalid && S_AXI.bready;
  assign fifo_pop = b_hs && !fifo_empty;

  // Capture a routed response, otherwise clear the stage once its master accepts it.
  always_comb begin
    out_d = out_q;
    if (fifo_pop) begin
      out_d.valid = 1'b1;
      out_d.sel   = fifo_head;
      out_d.resp  = S_AXI.bresp;
    end else if (out_q.valid && sel_bready) begin
      out_d.valid = 1'b0;
    end
  end

  // Output stage register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) out_q <= '0;
    else        out_q <= out_d;
  end

  assign M00_AXI.bvalid = out_q.valid && (out_q.sel == 1'b0);
  assign M01_AXI.bvalid = out_q.valid && (out_q.sel == 1'b1);
  assign M00_AXI.bresp  = (out_q.sel == 1'b0) ? out_q.resp : BRESP_OKAY;
  assign M01_AXI.bresp  = (out_q.sel == 1'b1) ? out_q.resp : BRESP_OKAY;

`ifdef B_ERR_CHECK_EN
  logic unexp_err_q;

  // Sticky flag: response with nothing outstanding, or a push the full tracker had to drop.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      unexp_err_q <= 1'b0;
    end else if ((b_hs && fifo_empty) || (aw_push && fifo_full && !fifo_pop)) begin
      unexp_err_q <= 1'b1;
    end
  end

  assign unexp_err = unexp_err_q;
`else
  assign unexp_err = 1'b0;
`endif

endmodule

// File: tb/tb_write_resp_router.sv
// Scoreboard bench for write_resp_router: stimulus tasks push expected
// {master, bresp} pairs, a negedge monitor pops them on each master handshake.
module tb_write_resp_router;
  import axi_ic_pkg::*;

  localparam int unsigned OT_DEPTH = 4;
`ifdef B_ERR_CHECK_EN
  localparam logic ERR_CHK = 1'b1;
`else
  localparam logic ERR_CHK = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        aw_push;
  master_idx_t aw_owner;
  logic        ot_full;
  logic [2:0]  ot_count;
  logic        unexp_err;

  write_resp_router_if s_if ();
  write_resp_router_if m00_if ();
  write_resp_router_if m01_if ();

  write_resp_router #(.OT_DEPTH(OT_DEPTH)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .aw_push   (aw_push),
    .aw_owner  (aw_owner),
    .ot_full   (ot_full),
    .ot_count  (ot_count),
    .S_AXI     (s_if),
    .M00_AXI   (m00_if),
    .M01_AXI   (m01_if),
    .unexp_err (unexp_err)
  );

  always #5 ACLK = ~ACLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [2:0]  exp_q[$];    // {master, bresp} expected at the masters, in order
  master_idx_t owner_q[$];  // reference model of the owner FIFO

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Master-side monitor: every accepted response must match the head of the scoreboard.
  task automatic sb_take(input logic mst, input bresp_t resp);
    logic [2:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL sb_unexpected: got master %0d bresp %0h, want no response", mst, resp);
    end else begin
      e = exp_q.pop_front();
      if ({mst, resp} !== e) begin
        miscompares++;
        $display("FAIL sb_route: got master %0d bresp %0h, want master %0d bresp %0h",
                 mst, resp, e[2], e[1:0]);
      end
    end
  endtask

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (ot_count > 3'(OT_DEPTH)) begin
        miscompares++;
        $display("FAIL ot_count_range: got %0d, want <= %0d", ot_count, OT_DEPTH);
      end
      if (m00_if.bvalid && m01_if.bvalid) begin
        miscompares++;
        $display("FAIL both_bvalid: got both masters valid, want at most one");
      end
      if (m00_if.bvalid && m00_if.bready) sb_take(1'b0, m00_if.bresp);
      if (m01_if.bvalid && m01_if.bready) sb_take(1'b1, m01_if.bresp);
    end
  end

  // Issue one AW toward the slave; the model drops it when the tracker is full.
  task automatic aw(input master_idx_t owner);
    aw_push  = 1'b1;
    aw_owner = owner;
    tick();
    aw_push  = 1'b0;
    if (owner_q.size() < OT_DEPTH) owner_q.push_back(owner);
  endtask

  // Present one slave response and hold it until accepted (bounded wait).
  task automatic send_b(input bresp_t resp);
    logic ok = 1'b0;
    s_if.bvalid = 1'b1;
    s_if.bresp  = resp;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (s_if.bready) begin
        ok = 1'b1;
        break;
      end
      @(posedge ACLK);
    end
    check("b_accept", {7'd0, ok}, 8'd1);
    if (ok && owner_q.size() > 0) exp_q.push_back({owner_q.pop_front(), resp});
    tick();
    s_if.bvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c0;
    logic [1:0] held;
    ARESET        = 1'b1;
    aw_push       = 1'b0;
    aw_owner      = 1'b0;
    s_if.bvalid   = 1'b0;
    s_if.bresp    = BRESP_OKAY;
    m00_if.bready = 1'b0;
    m01_if.bready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_count",   {5'd0, ot_count}, 8'd0);
    check("rst_full",    {7'd0, ot_full}, 8'd0);
    check("rst_m00_v",   {7'd0, m00_if.bvalid}, 8'd0);
    check("rst_m01_v",   {7'd0, m01_if.bvalid}, 8'd0);
    check("rst_m00_r",   {6'd0, m00_if.bresp}, 8'd0);
    check("rst_m01_r",   {6'd0, m01_if.bresp}, 8'd0);
    check("rst_unexp",   {7'd0, unexp_err}, 8'd0);
    check("rst_sbready", {7'd0, s_if.bready}, {7'd0, ERR_CHK});
    ARESET = 1'b0;
    tick();

    // Basic routing: owner 1, SLVERR, visible the cycle after the handshake
    m00_if.bready = 1'b1;
    m01_if.bready = 1'b1;
    aw(1'b1);
    check("basic_count1", {5'd0, ot_count}, 8'd1);
    send_b(BRESP_SLVERR);
    check("basic_m01_v",  {7'd0, m01_if.bvalid}, 8'd1);
    check("basic_m01_r",  {6'd0, m01_if.bresp}, 8'h2);
    check("basic_m00_v",  {7'd0, m00_if.bvalid}, 8'd0);
    check("basic_count0", {5'd0, ot_count}, 8'd0);
    tick();
    check("basic_drain",  {7'd0, m01_if.bvalid}, 8'd0);

    // Ordering: owners 0,1,1,0 with back-to-back responses
    aw(1'b0); aw(1'b1); aw(1'b1); aw(1'b0);
    check("ord_count4", {5'd0, ot_count}, 8'd4);
    check("ord_full",   {7'd0, ot_full}, 8'd1);
    c0 = cyc;
    send_b(BRESP_OKAY);
    send_b(BRESP_SLVERR);
    send_b(BRESP_OKAY);
    send_b(BRESP_DECERR);
    check("ord_cycles", 8'(cyc - c0), 8'd4);
    tick();
    check("ord_count0", {5'd0, ot_count}, 8'd0);

    // Backpressure: M00 holds off, M01 ready must not drain it
    m00_if.bready = 1'b0;
    m01_if.bready = 1'b1;
    aw(1'b0);
    aw(1'b1);
    send_b(BRESP_SLVERR);
    held = m00_if.bresp;
    check("bp_held_resp", {6'd0, held}, 8'h2);
    s_if.bvalid = 1'b1;
    s_if.bresp  = BRESP_EXOKAY;
    for (int i = 0; i < 5; i++) begin
      check("bp_m00_v",    {7'd0, m00_if.bvalid}, 8'd1);
      check("bp_m00_r",    {6'd0, m00_if.bresp}, {6'd0, held});
      check("bp_sbready",  {7'd0, s_if.bready}, 8'd0);
      check("bp_m01_v",    {7'd0, m01_if.bvalid}, 8'd0);
      tick();
    end
    m00_if.bready = 1'b1;
    send_b(BRESP_EXOKAY);
    check("bp_reload_m01", {7'd0, m01_if.bvalid}, 8'd1);
    tick();
    check("bp_count0", {5'd0, ot_count}, 8'd0);

    // Stray response with nothing outstanding
    s_if.bvalid = 1'b1;
    s_if.bresp  = BRESP_SLVERR;
    for (int i = 0; i < 3; i++) begin
      check("stray_sbready", {7'd0, s_if.bready}, {7'd0, ERR_CHK});
      tick();
      check("stray_m00_v", {7'd0, m00_if.bvalid}, 8'd0);
      check("stray_m01_v", {7'd0, m01_if.bvalid}, 8'd0);
    end
    check("stray_unexp", {7'd0, unexp_err}, {7'd0, ERR_CHK});
    check("stray_count", {5'd0, ot_count}, 8'd0);
    s_if.bvalid = 1'b0;
    tick();

    // Reset mid-burst: output held for M00 with three writes still tracked
    m00_if.bready = 1'b0;
    aw(1'b0); aw(1'b1); aw(1'b0); aw(1'b1);
    send_b(BRESP_OKAY);
    check("rmb_pre_count", {5'd0, ot_count}, 8'd3);
    check("rmb_pre_m00_v", {7'd0, m00_if.bvalid}, 8'd1);
    #2;
    ARESET = 1'b1;
    #1;
    check("rmb_m00_v",   {7'd0, m00_if.bvalid}, 8'd0);
    check("rmb_m01_v",   {7'd0, m01_if.bvalid}, 8'd0);
    check("rmb_m00_r",   {6'd0, m00_if.bresp}, 8'd0);
    check("rmb_count",   {5'd0, ot_count}, 8'd0);
    check("rmb_full",    {7'd0, ot_full}, 8'd0);
    check("rmb_unexp",   {7'd0, unexp_err}, 8'd0);
    check("rmb_sbready", {7'd0, s_if.bready}, {7'd0, ERR_CHK});
    exp_q.delete();
    owner_q.delete();
    tick();
    ARESET = 1'b0;
    m00_if.bready = 1'b1;
    tick();

    // Full: fill, overflow push, push+pop at full, then pop only
    aw(1'b1); aw(1'b0); aw(1'b1); aw(1'b0);
    check("full_count", {5'd0, ot_count}, 8'd4);
    check("full_flag",  {7'd0, ot_full}, 8'd1);
    aw(1'b0);
    check("ovf_count", {5'd0, ot_count}, 8'd4);
    check("ovf_unexp", {7'd0, unexp_err}, {7'd0, ERR_CHK});
    aw_push     = 1'b1;
    aw_owner    = 1'b1;
    s_if.bvalid = 1'b1;
    s_if.bresp  = BRESP_OKAY;
    @(negedge ACLK);
    check("pp_sbready", {7'd0, s_if.bready}, 8'd1);
    exp_q.push_back({owner_q.pop_front(), BRESP_OKAY});
    owner_q.push_back(1'b1);
    tick();
    aw_push     = 1'b0;
    s_if.bvalid = 1'b0;
    check("pp_count", {5'd0, ot_count}, 8'd4);
    check("pp_full",  {7'd0, ot_full}, 8'd1);
    send_b(BRESP_SLVERR);
    check("pop_count", {5'd0, ot_count}, 8'd3);
    check("pop_full",  {7'd0, ot_full}, 8'd0);
    send_b(BRESP_EXOKAY);
    send_b(BRESP_DECERR);
    send_b(BRESP_OKAY);
    tick();
    tick();
    check("end_count",   {5'd0, ot_count}, 8'd0);
    check("end_sb_empty", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
